io_responder: RTL and testbench

- Executes I/O instructions flagged by the control unit's io_code field.
- Sits in the execute stage, beside the ALU.
- Latches the request and stalls the pipeline while it runs a valid/ready handshake with the host I/O channel.
- Returns read data for register writeback, or halts the core on an END request.

---
 rtl/io_responder_pkg.sv | 27 ++
 rtl/io_timeout_counter.sv | 38 +++
 rtl/io_responder.sv | 170 +++++++++++++++++
 tb/tb_io_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared definitions for the execute-stage I/O responder:
// operation codes, FSM encodings and transmit kinds.
package io_responder_pkg;

  localparam logic [6:0] IO_NONE       = 7'd0;
  localparam logic [6:0] IO_PRINT_INT  = 7'd1;
  localparam logic [6:0] IO_PRINT_CHAR = 7'd2;
  localparam logic [6:0] IO_READ_INT   = 7'd3;
  localparam logic [6:0] IO_READ_CHAR  = 7'd4;
  localparam logic [6:0] IO_END        = 7'd5;

  localparam logic TX_KIND_INT  = 1'b0;
  localparam logic TX_KIND_CHAR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_RECV = 3'd2,
    ST_DONE = 3'd3,
    ST_HALT = 3'd4
  } io_state_e;

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Cycle counter for the I/O handshake wait states; expire is
// raised on the last permitted cycle. LIMIT of 0 never expires.
module io_timeout_counter
  import io_responder_pkg::*;
#(
  parameter int unsigned LIMIT = 0,
  parameter int unsigned W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [W-1:0] LAST =
    (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/io_responder.sv
// Execute-stage I/O unit: latches an I/O request, stalls the pipe
// while handshaking with the host channel, then reports completion.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [6:0]  io_code,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rdata,
  output logic        halted,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_kind,
  output logic        rx_req,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_data
);

  io_state_e   state_q;
  logic [6:0]  code_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_waddr_q;
  logic [31:0] rdata_q;
  logic        stall_q;
  logic        done_q;
  logic        err_q;
  logic        rd_we_q;
  logic        halted_q;
  logic        tx_valid_q;
  logic        rx_req_q;

  logic trig, is_print, is_read;
  logic in_send, in_recv, tx_hs, rx_hs;
  logic expire;

  assign is_print = (io_code == IO_PRINT_INT) ||
                    (io_code == IO_PRINT_CHAR);
  assign is_read  = (io_code == IO_READ_INT) ||
                    (io_code == IO_READ_CHAR);
  assign trig     = (state_q == ST_IDLE) && req_valid &&
                    (io_code != IO_NONE);

  assign in_send = (state_q == ST_SEND);
  assign in_recv = (state_q == ST_RECV);
  assign tx_hs   = in_send && tx_ready;
  assign rx_hs   = in_recv && rx_valid;

  io_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CNT_W)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!(in_send || in_recv)),
    .en_i     ((in_send && !tx_ready) ||
               (in_recv && !rx_valid)),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= IO_NONE;
      wdata_q    <= '0;
      rd_waddr_q <= '0;
      rdata_q    <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      rx_req_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (trig) begin
            code_q     <= io_code;
            wdata_q    <= wdata;
            rd_waddr_q <= rd_addr;
            unique case (1'b1)
              is_print: begin
                state_q    <= ST_SEND;
                stall_q    <= 1'b1;
                tx_valid_q <= 1'b1;
              end
              is_read: begin
                state_q  <= ST_RECV;
                stall_q  <= 1'b1;
                rx_req_q <= 1'b1;
              end
              (io_code == IO_END): begin
                state_q  <= ST_HALT;
                stall_q  <= 1'b1;
                halted_q <= 1'b1;
              end
              default: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_SEND: begin
          // a handshake on the expiry cycle still counts as success
          if (tx_hs || expire) begin
            state_q    <= ST_DONE;
            stall_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= !tx_hs;
          end
        end
        ST_RECV: begin
          if (rx_hs) begin
            state_q  <= ST_DONE;
            stall_q  <= 1'b0;
            rx_req_q <= 1'b0;
            done_q   <= 1'b1;
            rd_we_q  <= (rd_waddr_q != 5'd0);
            rdata_q  <= (code_q == IO_READ_CHAR) ?
                        zext8(rx_data[7:0]) : rx_data;
          end else if (expire) begin
            state_q  <= ST_DONE;
            stall_q  <= 1'b0;
            rx_req_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall    = stall_q || trig;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_we    = rd_we_q;
  assign rd_waddr = rd_waddr_q;
  assign rdata    = rdata_q;
  assign halted   = halted_q;
  assign tx_valid = tx_valid_q;
  assign tx_kind  = (code_q == IO_PRINT_CHAR) ?
                    TX_KIND_CHAR : TX_KIND_INT;
  assign tx_data  = (code_q == IO_PRINT_CHAR) ?
                    zext8(wdata_q[7:0]) : wdata_q;
  assign rx_req   = rx_req_q;
  assign rx_ready = rx_req_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: host-side models for the
// tx/rx channels, completion and transmit queues checked on negedge.
module tb_io_responder;
  import io_responder_pkg::*;

  logic        clk, rst;
  logic        req_valid;
  logic [6:0]  io_code;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;
  logic        stall, done, err, rd_we, halted;
  logic [4:0]  rd_waddr;
  logic [31:0] rdata;
  logic        tx_valid, tx_ready, tx_kind;
  logic [31:0] tx_data;
  logic        rx_req, rx_valid, rx_ready;
  logic [31:0] rx_data;

  io_responder #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .io_code   (io_code),
    .wdata     (wdata),
    .rd_addr   (rd_addr),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rd_we     (rd_we),
    .rd_waddr  (rd_waddr),
    .rdata     (rdata),
    .halted    (halted),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_kind   (tx_kind),
    .rx_req    (rx_req),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data)
  );

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] rdata;
    int          lat;
  } done_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        kind;
  } tx_exp_t;

  done_exp_t   doneq[$];
  tx_exp_t     txq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          trig_cyc = 0;
  int          tx_delay = 0, tx_wait = 0;
  int          rx_delay = 0, rx_wait = 0;
  logic [31:0] model_rdata = '0;
  logic        tx_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h",
               tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // host transmit side: accept after tx_delay waiting cycles
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_valid) begin
        tx_ready = (tx_wait == tx_delay);
        tx_wait++;
      end else begin
        tx_ready = 1'b0;
        tx_wait  = 0;
      end
    end
  end

  // host receive side: supply data after rx_delay waiting cycles
  initial begin
    rx_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rx_req) begin
        rx_valid = (rx_wait == rx_delay);
        rx_wait++;
      end else begin
        rx_valid = 1'b0;
        rx_wait  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      if (doneq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        done_exp_t e;
        e = doneq.pop_front();
        chk("err", err, e.err);
        chk("rd_we", rd_we, e.we);
        chk("rd_waddr", rd_waddr, e.waddr);
        chk("rdata", rdata, e.rdata);
        chk("latency", cyc - trig_cyc, e.lat);
        chk("tx_valid_in_done", tx_valid, 1'b0);
        chk("rx_req_in_done", rx_req, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        if (txq.size() == 0) begin
          chk("spurious_tx", 32'd1, 32'd0);
        end else begin
          chk("tx_data", tx_data, txq[0].data);
          chk("tx_kind", tx_kind, txq[0].kind);
        end
      end
      if (tx_prev && !tx_valid && txq.size() != 0)
        void'(txq.pop_front());
    end
    tx_prev <= tx_valid;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_done(input logic e, input logic we,
                           input logic [4:0] wa,
                           input logic [31:0] rd, input int lat);
    done_exp_t d;
    d.err = e; d.we = we; d.waddr = wa;
    d.rdata = rd; d.lat = lat;
    doneq.push_back(d);
  endtask

  task automatic push_tx(input logic [31:0] d, input logic k);
    tx_exp_t t;
    t.data = d; t.kind = k;
    txq.push_back(t);
  endtask

  // hold the request like a stalled pipeline until done is seen
  task automatic run_op(input logic [6:0] code,
                        input logic [31:0] wd,
                        input logic [4:0] rd, input int lat);
    int n = 0, stl = 0;
    bit seen = 0;
    req_valid = 1'b1; io_code = code;
    wdata = wd; rd_addr = rd; trig_cyc = cyc;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk("stall_in_done", stall, 1'b0);
      end else if (stall) begin
        stl++;
      end
      n++;
      @(posedge clk); #1;
    end
    chk("done_seen", seen, 1'b1);
    chk("stall_cycles", stl, lat);
    req_valid = 1'b0; io_code = IO_NONE;
  endtask

  initial begin
    int bad;
    rst = 1'b1; req_valid = 1'b0; io_code = IO_NONE;
    wdata = '0; rd_addr = '0; rx_data = '0;
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_req", rx_req, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    tx_delay = 0;
    push_tx(32'hDEADBEEF, TX_KIND_INT);
    push_done(1'b0, 1'b0, 5'd2, model_rdata, 2);
    run_op(IO_PRINT_INT, 32'hDEADBEEF, 5'd2, 2);
    step();

    rx_delay = 4; rx_data = 32'h12345641;
    model_rdata = 32'h00000041;
    push_done(1'b0, 1'b1, 5'd5, model_rdata, 6);
    run_op(IO_READ_CHAR, 32'h0, 5'd5, 6);
    step();

    rx_delay = 0; rx_data = 32'hCAFEF00D;
    model_rdata = 32'hCAFEF00D;
    push_done(1'b0, 1'b0, 5'd0, model_rdata, 2);
    run_op(IO_READ_INT, 32'h0, 5'd0, 2);
    step();

    push_done(1'b1, 1'b0, 5'd7, model_rdata, 1);
    run_op(7'd9, 32'h55, 5'd7, 1);
    step();

    tx_delay = 99;
    push_tx(32'h00000044, TX_KIND_CHAR);
    push_done(1'b1, 1'b0, 5'd1, model_rdata, 9);
    run_op(IO_PRINT_CHAR, 32'h11223344, 5'd1, 9);
    step();

    tx_delay = 7;
    push_tx(32'h0000007A, TX_KIND_CHAR);
    push_done(1'b0, 1'b0, 5'd1, model_rdata, 9);
    run_op(IO_PRINT_CHAR, 32'hABCDEF7A, 5'd1, 9);
    step();

    rx_delay = 99; rx_data = 32'h99999999;
    push_done(1'b1, 1'b0, 5'd9, model_rdata, 9);
    run_op(IO_READ_INT, 32'h0, 5'd9, 9);
    step();

    rx_delay = 2; rx_data = 32'h80000001;
    model_rdata = 32'h80000001;
    push_done(1'b0, 1'b1, 5'd31, model_rdata, 4);
    run_op(IO_READ_INT, 32'h0, 5'd31, 4);
    step();

    rx_delay = 99;
    req_valid = 1'b1; io_code = IO_READ_INT; rd_addr = 5'd3;
    repeat (3) step();
    @(negedge clk);
    chk("recv_rx_req", rx_req, 1'b1);
    chk("recv_rx_ready", rx_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; io_code = IO_NONE;
    #1;
    chk("midrst_rx_req", rx_req, 1'b0);
    chk("midrst_rx_ready", rx_ready, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_rdata", rdata, 32'd0);
    step();
    rst = 1'b0; model_rdata = '0;
    step();
    tx_delay = 1;
    push_tx(32'h0BADF00D, TX_KIND_INT);
    push_done(1'b0, 1'b0, 5'd4, model_rdata, 3);
    run_op(IO_PRINT_INT, 32'h0BADF00D, 5'd4, 3);
    step();

    req_valid = 1'b1; io_code = IO_END;
    @(negedge clk);
    chk("end_trig_stall", stall, 1'b1);
    bad = 0;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (!(halted && stall)) bad++;
    end
    chk("halt_hold", bad, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; io_code = IO_NONE;
    @(negedge clk);
    chk("halt_after_req_drop", halted, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", halted, 1'b0);
    chk("halt_rst_stall", stall, 1'b0);
    step();
    rst = 1'b0; model_rdata = '0;
    step();

    tx_delay = 0;
    push_tx(32'h00000123, TX_KIND_INT);
    push_done(1'b0, 1'b0, 5'd6, model_rdata, 2);
    run_op(IO_PRINT_INT, 32'h00000123, 5'd6, 2);
    repeat (3) step();

    chk("done_queue_empty", doneq.size(), 0);
    chk("tx_queue_empty", txq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
